// File: rtl/player_state_sequencer_pkg.sv
// Shared encodings for the player sequencer and hit detection: states, stunmodes,
// frame durations, move speeds and playfield geometry.
package player_state_sequencer_pkg;

  typedef logic [3:0] pstate_t;
  typedef logic [1:0] stunmode_t;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_FWD         = 4'd1;
  localparam logic [3:0] ST_BACK        = 4'd2;
  localparam logic [3:0] ST_NATK_START  = 4'd3;
  localparam logic [3:0] ST_NATK_ACTIVE = 4'd4;
  localparam logic [3:0] ST_NATK_REC    = 4'd5;
  localparam logic [3:0] ST_DATK_START  = 4'd6;
  localparam logic [3:0] ST_DATK_ACTIVE = 4'd7;
  localparam logic [3:0] ST_DATK_REC    = 4'd8;
  localparam logic [3:0] ST_HITSTUN     = 4'd9;
  localparam logic [3:0] ST_BLOCKSTUN   = 4'd10;
  localparam logic [3:0] ST_DEAD        = 4'd11;

  localparam logic [1:0] SM_NEUTRAL = 2'b00;
  localparam logic [1:0] SM_HIT     = 2'b01;
  localparam logic [1:0] SM_BLOCK   = 2'b10;
  localparam logic [1:0] SM_WHIFF   = 2'b11;

  localparam logic [4:0] DUR_NATK_START  = 5'd5;
  localparam logic [4:0] DUR_NATK_ACTIVE = 5'd2;
  localparam logic [4:0] DUR_NATK_REC    = 5'd16;
  localparam logic [4:0] DUR_DATK_START  = 5'd4;
  localparam logic [4:0] DUR_DATK_ACTIVE = 5'd3;
  localparam logic [4:0] DUR_DATK_REC    = 5'd15;
  localparam logic [4:0] DUR_HITSTUN     = 5'd15;
  localparam logic [4:0] DUR_BLOCKSTUN   = 5'd3;

  localparam logic signed [3:0] SPEED_FWD  = 4'sd3;
  localparam logic signed [3:0] SPEED_BACK = 4'sd2;

  localparam int         BASE_WIDTH = 64;
  localparam logic [9:0] X_MAX      = 10'd576;

endpackage

// File: rtl/player_state_sequencer_if.sv
// Button/stun inputs and state/position outputs between the sequencer and its neighbours.
interface player_state_sequencer_if;
  import player_state_sequencer_pkg::*;

  logic      frame_tick;
  logic      btn_left;
  logic      btn_right;
  logic      btn_atk;
  stunmode_t stunmode;
  pstate_t   state;
  logic [9:0] x;
  logic [2:0] shield;
  logic [2:0] health;
  logic       dead;

  modport master (
    output frame_tick, btn_left, btn_right, btn_atk, stunmode,
    input  state, x, shield, health, dead
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_atk, stunmode,
    output state, x, shield, health, dead
  );
endinterface

// File: rtl/player_state_sequencer_frame_counter.sv
// 5-bit per-state frame counter: load on entry, count down on ticks, expire at 1.
module player_state_sequencer_frame_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic       expire
);
  logic [4:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (tick) begin
      if (load)
        cnt <= load_val;
      else if (cnt != 5'd0)
        cnt <= cnt - 5'd1;
    end
  end

  // A state loaded with N is left on the tick that sees the count at 1, so it lasts N ticks.
  assign expire = (cnt == 5'd1);
endmodule

// File: rtl/player_state_sequencer.sv
// Per-player frame-driven sequencer: buttons and hit verdicts to state, x, shield, health.
module player_state_sequencer
  import player_state_sequencer_pkg::*;
#(
  parameter bit         IS_P2       = 1'b0,
  parameter logic [9:0] X_INIT      = 10'd100,
  parameter logic [2:0] SHIELD_INIT = 3'd3,
  parameter logic [2:0] HEALTH_INIT = 3'd3
) (
  input logic                     clk,
  input logic                     rst_n,
  player_state_sequencer_if.slave bus
);
  pstate_t    state_r, st_n;
  logic [9:0] x_r, x_n;
  logic [2:0] shield_r, sh_n, health_r, hp_n;
  stunmode_t  stun_prev;
  logic       dead_r;
  logic       fwd, back, hit_req, ld, expire;
  logic [4:0] ld_val;
  logic signed [3:0]  dx;
  logic signed [10:0] x_sum;

  // P2 faces left, so the meaning of left/right swaps; both pressed cancels out.
  always_comb begin
    fwd  = IS_P2 ? (bus.btn_left & ~bus.btn_right) : (bus.btn_right & ~bus.btn_left);
    back = IS_P2 ? (bus.btn_right & ~bus.btn_left) : (bus.btn_left & ~bus.btn_right);
    dx   = fwd ? SPEED_FWD : (back ? -SPEED_BACK : 4'sd0);
    if (IS_P2) dx = -dx;
    x_sum = $signed({1'b0, x_r}) + $signed({{7{dx[3]}}, dx});
  end

  assign hit_req = ((bus.stunmode == SM_HIT) || (bus.stunmode == SM_BLOCK)) &&
                   (bus.stunmode != stun_prev) &&
                   (state_r != ST_HITSTUN) && (state_r != ST_BLOCKSTUN) && (state_r != ST_DEAD);

  always_comb begin
    st_n   = state_r;
    x_n    = x_r;
    sh_n   = shield_r;
    hp_n   = health_r;
    ld     = 1'b0;
    ld_val = 5'd0;
    if (state_r == ST_DEAD) begin
      st_n = ST_DEAD;
    end else if (hit_req) begin
      if (bus.stunmode == SM_HIT) begin
        hp_n = (health_r == 3'd0) ? 3'd0 : health_r - 3'd1;
        if (hp_n == 3'd0) begin
          st_n = ST_DEAD;
        end else begin
          st_n = ST_HITSTUN; ld = 1'b1; ld_val = DUR_HITSTUN;
        end
      end else begin
        sh_n = (shield_r == 3'd0) ? 3'd0 : shield_r - 3'd1;
        st_n = ST_BLOCKSTUN; ld = 1'b1; ld_val = DUR_BLOCKSTUN;
      end
    end else if (state_r <= ST_BACK) begin
      if (bus.btn_atk && (fwd || back)) begin
        st_n = ST_DATK_START; ld = 1'b1; ld_val = DUR_DATK_START;
      end else if (bus.btn_atk) begin
        st_n = ST_NATK_START; ld = 1'b1; ld_val = DUR_NATK_START;
      end else begin
        st_n = fwd ? ST_FWD : (back ? ST_BACK : ST_IDLE);
        if (x_sum < 11'sd0)                        x_n = 10'd0;
        else if (x_sum > $signed({1'b0, X_MAX}))   x_n = X_MAX;
        else                                       x_n = x_sum[9:0];
      end
    end else if (expire) begin
      case (state_r)
        ST_NATK_START:  begin st_n = ST_NATK_ACTIVE; ld = 1'b1; ld_val = DUR_NATK_ACTIVE; end
        ST_NATK_ACTIVE: begin st_n = ST_NATK_REC;    ld = 1'b1; ld_val = DUR_NATK_REC;    end
        ST_DATK_START:  begin st_n = ST_DATK_ACTIVE; ld = 1'b1; ld_val = DUR_DATK_ACTIVE; end
        ST_DATK_ACTIVE: begin st_n = ST_DATK_REC;    ld = 1'b1; ld_val = DUR_DATK_REC;    end
        default:        st_n = ST_IDLE;
      endcase
    end
  end

  player_state_sequencer_frame_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (bus.frame_tick),
    .load     (ld),
    .load_val (ld_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      x_r       <= X_INIT;
      shield_r  <= SHIELD_INIT;
      health_r  <= HEALTH_INIT;
      stun_prev <= SM_NEUTRAL;
      dead_r    <= 1'b0;
    end else if (bus.frame_tick) begin
      state_r   <= st_n;
      x_r       <= x_n;
      shield_r  <= sh_n;
      health_r  <= hp_n;
      stun_prev <= bus.stunmode;
      dead_r    <= (st_n == ST_DEAD);
    end
  end

  assign bus.state  = state_r;
  assign bus.x      = x_r;
  assign bus.shield = shield_r;
  assign bus.health = health_r;
  assign bus.dead   = dead_r;
endmodule

// File: tb/tb_player_state_sequencer.sv
// Bench for player_state_sequencer: P1 and P2 instances on shared stimulus, checked
// every cycle against a schedule-based behavioural model plus literal expectations.
module tb_player_state_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0, bl = 1'b0, br = 1'b0, ba = 1'b0;
  logic [1:0] sm = 2'b00;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  player_state_sequencer_if b0 ();
  player_state_sequencer_if b1 ();

  assign b0.frame_tick = tick; assign b1.frame_tick = tick;
  assign b0.btn_left   = bl;   assign b1.btn_left   = bl;
  assign b0.btn_right  = br;   assign b1.btn_right  = br;
  assign b0.btn_atk    = ba;   assign b1.btn_atk    = ba;
  assign b0.stunmode   = sm;   assign b1.stunmode   = sm;

  player_state_sequencer #(.IS_P2(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  player_state_sequencer #(.IS_P2(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic check(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each timed sequence is an explicit per-tick list of states to play out.
  int m_state[2], m_x[2], m_sh[2], m_hp[2], m_prev[2];
  int sched[2][32];
  int slen[2], spos[2];

  task automatic m_reset(int p);
    m_state[p] = 0; m_x[p] = 100; m_sh[p] = 3; m_hp[p] = 3; m_prev[p] = 0;
    slen[p] = 0; spos[p] = 0;
  endtask

  task automatic m_push(int p, int st, int n);
    for (int i = 0; i < n; i++) begin
      sched[p][slen[p]] = st;
      slen[p]++;
    end
  endtask

  task automatic m_start(int p, int s0, int n0, int s1, int n1, int s2, int n2);
    slen[p] = 0;
    m_push(p, s0, n0); m_push(p, s1, n1); m_push(p, s2, n2);
    m_state[p] = sched[p][0];
    spos[p] = 1;
  endtask

  task automatic m_tick(int p);
    bit f, b, hit;
    int dx, nx;
    f = (p == 1) ? (bl && !br) : (br && !bl);
    b = (p == 1) ? (br && !bl) : (bl && !br);
    hit = (sm == 2'd1 || sm == 2'd2) && (int'(sm) != m_prev[p]) && (m_state[p] < 9);
    m_prev[p] = int'(sm);
    if (m_state[p] == 11) return;
    if (hit) begin
      if (sm == 2'd1) begin
        m_hp[p] = m_hp[p] - 1;
        if (m_hp[p] == 0) m_state[p] = 11;
        else m_start(p, 9, 15, 0, 0, 0, 0);
      end else begin
        if (m_sh[p] > 0) m_sh[p] = m_sh[p] - 1;
        m_start(p, 10, 3, 0, 0, 0, 0);
      end
    end else if (m_state[p] <= 2) begin
      if (ba && (f || b)) m_start(p, 6, 4, 7, 3, 8, 15);
      else if (ba)        m_start(p, 3, 5, 4, 2, 5, 16);
      else begin
        m_state[p] = f ? 1 : (b ? 2 : 0);
        dx = f ? 3 : (b ? -2 : 0);
        if (p == 1) dx = -dx;
        nx = m_x[p] + dx;
        m_x[p] = (nx < 0) ? 0 : ((nx > 576) ? 576 : nx);
      end
    end else if (spos[p] < slen[p]) begin
      m_state[p] = sched[p][spos[p]];
      spos[p]++;
    end else begin
      m_state[p] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset(0); m_reset(1);
    end else if (tick) begin
      m_tick(0); m_tick(1);
    end
  end

  task automatic cmp(int p, int st, int x, int sh, int hp, int dd);
    check($sformatf("p%0d_state", p), st, m_state[p]);
    check($sformatf("p%0d_x", p), x, m_x[p]);
    check($sformatf("p%0d_shield", p), sh, m_sh[p]);
    check($sformatf("p%0d_health", p), hp, m_hp[p]);
    check($sformatf("p%0d_dead", p), dd, (m_state[p] == 11) ? 1 : 0);
  endtask

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, int'(b0.state), int'(b0.x), int'(b0.shield), int'(b0.health), int'(b0.dead));
      cmp(1, int'(b1.state), int'(b1.x), int'(b1.shield), int'(b1.health), int'(b1.dead));
    end
  end

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  int rec[32];
  task automatic rec_run(int n);
    for (int i = 0; i < n; i++) begin
      do_tick();
      ba = 1'b0;
      rec[i] = int'(b0.state);
    end
  endtask

  function automatic int count_of(int v, int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (rec[i] == v) c++;
    return c;
  endfunction

  initial begin
    int x_save;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_state", int'(b0.state), 0);
    check("rst_x", int'(b0.x), 100);
    check("rst_shield", int'(b0.shield), 3);
    check("rst_health", int'(b0.health), 3);
    check("rst_dead", int'(b0.dead), 0);
    @(negedge clk) rst_n = 1'b1;

    br = 1'b1; repeat (10) do_tick();
    check("p1_fwd10_state", int'(b0.state), 1);
    check("p1_fwd10_x", int'(b0.x), 130);
    check("p2_back10_state", int'(b1.state), 2);
    check("p2_back10_x", int'(b1.x), 120);
    br = 1'b0; pulse_reset();

    bl = 1'b1; repeat (10) do_tick();
    check("p1_back10_x", int'(b0.x), 80);
    check("p2_fwd10_state", int'(b1.state), 1);
    check("p2_fwd10_x", int'(b1.x), 70);
    bl = 1'b0; br = 1'b1; repeat (165) do_tick();
    check("p1_x575", int'(b0.x), 575);
    do_tick();
    check("p1_clamp_hi", int'(b0.x), 576);
    br = 1'b0; bl = 1'b1; repeat (293) do_tick();
    check("p1_clamp_lo", int'(b0.x), 0);
    check("p1_clamp_lo_state", int'(b0.state), 2);
    bl = 1'b0;

    ba = 1'b1; rec_run(24);
    check("natk_s3", count_of(3, 24), 5);
    check("natk_s4", count_of(4, 24), 2);
    check("natk_s5", count_of(5, 24), 16);
    check("natk_end", rec[23], 0);

    br = 1'b1; ba = 1'b1; rec_run(23);
    check("datk_s6", count_of(6, 23), 4);
    check("datk_s7", count_of(7, 23), 3);
    check("datk_s8", count_of(8, 23), 15);
    check("datk_end", rec[22], 0);
    br = 1'b0;

    ba = 1'b1; rec_run(6);
    check("hit_pre_active", rec[5], 4);
    sm = 2'd1; repeat (3) do_tick();
    check("hit_state", int'(b0.state), 9);
    check("hit_health_once", int'(b0.health), 2);
    sm = 2'd0; repeat (12) do_tick();
    check("hitstun_hold", int'(b0.state), 9);
    do_tick();
    check("hitstun_end", int'(b0.state), 0);
    for (int k = 0; k < 2; k++) begin
      sm = 2'd1; do_tick();
      sm = 2'd0; repeat (16) do_tick();
    end
    check("dead_health", int'(b0.health), 0);
    check("dead_state", int'(b0.state), 11);
    check("dead_flag", int'(b0.dead), 1);
    x_save = int'(b0.x);
    ba = 1'b1; br = 1'b1; repeat (5) do_tick();
    check("dead_hold_state", int'(b0.state), 11);
    check("dead_hold_x", int'(b0.x), x_save);
    ba = 1'b0; br = 1'b0;

    pulse_reset();
    sm = 2'd2; do_tick();
    check("block_state", int'(b0.state), 10);
    check("block_shield", int'(b0.shield), 2);
    sm = 2'd0; repeat (2) do_tick();
    check("blockstun_hold", int'(b0.state), 10);
    do_tick();
    check("blockstun_end", int'(b0.state), 0);
    repeat (2) begin
      sm = 2'd2; do_tick();
      sm = 2'd0; repeat (3) do_tick();
    end
    check("shield_zero", int'(b0.shield), 0);
    sm = 2'd2; do_tick();
    check("shield_sat", int'(b0.shield), 0);
    check("shield_sat_state", int'(b0.state), 10);
    sm = 2'd0; repeat (3) do_tick();

    sm = 2'd1; do_tick();
    check("rst_mid_pre", int'(b0.state), 9);
    sm = 2'd0; repeat (2) do_tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(b0.state), 0);
    check("async_rst_x", int'(b0.x), 100);
    check("async_rst_shield", int'(b0.shield), 3);
    check("async_rst_health", int'(b0.health), 3);
    check("async_rst_dead", int'(b0.dead), 0);
    @(negedge clk) rst_n = 1'b1;
    do_tick();
    check("post_rst_idle", int'(b0.state), 0);

    // Random phase: sparse ticks, sticky buttons, occasional stun changes and resets.
    for (int c = 0; c < 9000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      if (tick) tick = 1'b0;
      else if ($urandom_range(0, 2) == 0) begin
        tick = 1'b1;
        if ($urandom_range(0, 3) == 0) bl = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) br = ($urandom_range(0, 2) == 0);
        ba = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 4) == 0) sm = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/player_state_sequencer.md
# player_state_sequencer

Per-player frame-driven state machine that turns button inputs and hit-detection verdicts into the 4-bit player state, horizontal position, shield count and health that the hit-detection and rendering logic consume. One instance per player sits between the input synchroniser and hit detection: its `state`/`x`/`shield` outputs feed hit detection, and hit detection's `stunmode` for this player feeds back in. All sequencing advances only on the 60 Hz frame tick.

## Interface
- `IS_P2`, default 0: 0 = player 1 (faces right), 1 = player 2 (faces left; left/right buttons swap meaning).
- `X_INIT`, default 10'd100: reset x (top-left corner).
- `SHIELD_INIT`, default 3'd3: reset shield count.
- `HEALTH_INIT`, default 3'd3: reset health.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_tick`  in  1  one-`clk` pulse per frame; all state updates gated by it.
- `btn_left`, `btn_right`, `btn_atk`  in  1 each  synchronised, level-sensitive buttons.
- `stunmode`  in  2  from hit detection: 00 neutral, 01 hitstun, 10 blockstun, 11 whiff.
- `state`  out  4  0 idle, 1 forward, 2 backward, 3/4/5 neutral-attack start/active/recovery, 6/7/8 directional-attack start/active/recovery, 9 hitstun, 10 blockstun, 11 dead.
- `x`  out  10  top-left x, 0..576.
- `shield`  out  3  remaining blocks.
- `health`  out  3  remaining hits.
- `dead`  out  1  high while `state`==11.

## Operation
- Reset: `state`=0, `x`=`X_INIT`, `shield`=`SHIELD_INIT`, `health`=`HEALTH_INIT`, `dead`=0, frame counter=0, `stun_prev`=00.
- `fwd`/`back` are derived from the buttons via `IS_P2`. P1: fwd=right, back=left. P2: fwd=left, back=right. Both pressed is treated as neither.
- Hit trigger: on a tick, `stunmode`∈{01,10}, `stunmode`≠`stun_prev`, and `state`∉{9,10,11}. `stun_prev` updates every tick.
- Priority per tick: dead > hit trigger > current-state sequencing.
- Entering hitstun (01):
  - `health` is decremented.
  - If the new health is 0, go to state 11; otherwise go to state 9 with counter=15.
  - Any attack in progress is abandoned.
- Entering blockstun (10): `shield` is decremented, saturating at 0. Go to state 10 with counter=3.
- Idle/forward/backward:
  - `btn_atk` with fwd or back goes to 6 (counter=4).
  - `btn_atk` alone goes to 3 (counter=5).
  - Otherwise `state` is 1 if fwd, 2 if back, else 0.
  - Movement: forward ±3 px per tick, backward ±2 px per tick, in the facing direction.
  - `x` is clamped to 0..576; clamping uses a 11-bit intermediate, never a wrapped value.
- Timed states: the counter decrements each tick. On the tick where counter==1, advance:
  - 3→4 (2), 4→5 (16), 5→0.
  - 6→7 (3), 7→8 (15), 8→0.
  - 9→0, 10→0.
- No movement occurs in attack or stun states. `btn_atk` is ignored outside idle/forward/backward (no buffering).
- State 11 is terminal until reset.

## Timing
- Outputs are registered. They change only on the `clk` edge where `frame_tick`=1, so `state` is valid one `clk` after the tick.
- Counter semantics: a state loaded with N lasts exactly N ticks.
- Neutral attack total is 23 ticks; directional attack total is 22 ticks.
- `stunmode` is sampled only on the tick. Hit detection updates every `clk`, so it is stable well before the next tick.
- Asynchronous reset mid-attack or mid-stun returns all outputs to reset values immediately, independent of `clk`.

## Structure
- Shared package (also used by hit detection):
  - State encodings 0–11.
  - Stunmode codes.
  - Frame durations (5/2/16, 4/3/15, 15, 3).
  - Move speeds 3/2.
  - `BASE_WIDTH`=64.
  - `X_MAX`=576.
- One natural sub-module: `frame_counter` (5-bit load/decrement/expire on tick).
- Direction mapping and clamp stay inline.

## Test plan
- Idle, hold fwd 10 ticks (P1, `X_INIT`=100): `state`=1, `x`=130. Same with `IS_P2`=1 and `btn_left`: `x`=70.
- P1 at `x`=575, fwd 1 tick → `x`=576. Then back to 0 via `btn_left` held, and `x` stays 0; no wrap.
- `btn_atk` pulse: state 3 for 5 ticks, 4 for 2, 5 for 16, then 0. With fwd held, 6/7/8 last 4/3/15 ticks.
- During state 4, `stunmode`=01 for 3 ticks → state 9 for 15 ticks, `health` 3→2 once only. Repeat until health=0 → state 11, `dead`=1, buttons ignored.
- `stunmode` 00→10 while idle → state 10 for 3 ticks, `shield` 3→2. At `shield`=0, a further 10 → `shield` stays 0.
- Assert `rst_n`=0 mid-hitstun between ticks → outputs equal reset values without waiting for `clk`. Release → idle on next tick.
